// File: rtl/am_mod_pipe_if.sv
// am_mod_pipe_if: sample/depth bus of the AM modulator.
// The DDS side drives through the master modport; the modulator uses slave.
interface am_mod_pipe_if #(
    parameter int DW = 14,
    parameter int MW = 8
);
    logic          in_valid;
    logic [DW-1:0] carrier;
    logic [DW-1:0] modulating;
    logic [MW-1:0] depth;
    logic          depth_load;
    logic          out_valid;
    logic [DW-1:0] am_sig;
    logic          depth_busy;

    modport master (
        output in_valid, carrier, modulating, depth, depth_load,
        input  out_valid, am_sig, depth_busy
    );

    modport slave (
        input  in_valid, carrier, modulating, depth, depth_load,
        output out_valid, am_sig, depth_busy
    );
endinterface

// File: rtl/am_mod_pipe.sv
// am_mod_pipe: pipelined AM modulator, offset-binary in and out.
//   am = c * (bias + x*m / 2^MW) / 2^DW, valid-qualified, no backpressure.
// Optional feature macro AM_DEPTH_RAMP_EN: when defined, depth changes ramp
// one LSB per accepted sample through a small FSM; otherwise depth_load
// applies the new depth immediately.
module am_mod_pipe #(
    parameter int DW = 14,
    parameter int MW = 8
) (
    input  logic          clk_100M,
    input  logic          rst,
    am_mod_pipe_if.slave  bus
);
    localparam int STAGES = 3;
    localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ENV_BIAS = {1'b0, {(DW-1){1'b1}}};

    // vld_pipe[0] tracks stage 1, vld_pipe[STAGES] is out_valid
    logic [STAGES:0]        vld_pipe;
    logic [MW-1:0]          m_cur;

    logic signed [DW-1:0]   x1, c1;
    logic [MW-1:0]          m1;
    logic [DW-1:0]          env2;
    logic signed [DW-1:0]   c2;
    logic signed [DW-1:0]   y3;
    logic [DW-1:0]          am_q;

    logic signed [DW+MW:0]  p_full;
    logic [DW-1:0]          env_c;
    logic signed [2*DW:0]   prod;
    logic                   unused_bits;

    // Valid shift register; bubbles travel with the data
    always_ff @(posedge clk_100M) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
    end

    // x*m fits in DW+MW bits; taking bits [DW+MW-1:MW] is the floor shift.
    // env stays within [0, 2^DW-1] for every input, so no clipping.
    assign p_full = $signed({{(MW+1){x1[DW-1]}}, x1}) * $signed({{(DW+1){1'b0}}, m1});
    assign env_c  = ENV_BIAS + p_full[DW+MW-1:MW];
    // env is unsigned, zero-extend before the signed multiply; high half is y
    assign prod   = $signed({{(DW+1){1'b0}}, env2}) * $signed({{(DW+1){c2[DW-1]}}, c2});
    assign unused_bits = ^{p_full[DW+MW], p_full[MW-1:0], prod[2*DW], prod[DW-1:0]};

    // Data stages: input capture, envelope, carrier product, output
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            x1   <= '0;
            c1   <= '0;
            m1   <= '0;
            env2 <= '0;
            c2   <= '0;
            y3   <= '0;
            am_q <= MID;
        end else begin
            x1   <= {~bus.modulating[DW-1], bus.modulating[DW-2:0]};
            c1   <= {~bus.carrier[DW-1], bus.carrier[DW-2:0]};
            m1   <= m_cur;
            env2 <= env_c;
            c2   <= c1;
            y3   <= prod[2*DW-1:DW];
            if (vld_pipe[STAGES-1]) am_q <= {~y3[DW-1], y3[DW-2:0]};
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.am_sig    = am_q;

`ifdef AM_DEPTH_RAMP_EN
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t        state, state_nxt;
    logic [MW-1:0] target, target_nxt, m_nxt;
    logic          ramping;

    // Depth FSM state, target and current depth registers
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state  <= IDLE;
            target <= '0;
            m_cur  <= '0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            m_cur  <= m_nxt;
        end
    end

    // Retarget takes effect this cycle; step only on accepted samples
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        m_nxt      = m_cur;
        ramping    = 1'b0;
        case (state)
            IDLE:     ramping = bus.depth_load;
            UP, DOWN: ramping = 1'b1;
            default:  ramping = 1'b0;
        endcase
        if (bus.depth_load) target_nxt = bus.depth;
        if (ramping) begin
            if (bus.in_valid && target_nxt > m_cur)      m_nxt = m_cur + MW'(1);
            else if (bus.in_valid && target_nxt < m_cur) m_nxt = m_cur - MW'(1);
            if (target_nxt > m_nxt)      state_nxt = UP;
            else if (target_nxt < m_nxt) state_nxt = DOWN;
            else                         state_nxt = IDLE;
        end
    end

    assign bus.depth_busy = (state != IDLE);
`else
    // Immediate depth update; the sample on the same edge sees the old depth
    always_ff @(posedge clk_100M) begin
        if (rst)                 m_cur <= '0;
        else if (bus.depth_load) m_cur <= bus.depth;
    end

    assign bus.depth_busy = 1'b0;
`endif
endmodule

// File: tb/tb_am_mod_pipe.sv
// tb_am_mod_pipe: directed + random stimulus against an arithmetic model of
// the AM modulator (floor divisions, sample queue for the 3-cycle latency).
// Follows AM_DEPTH_RAMP_EN the same way the design does.
module tb_am_mod_pipe;
    localparam int DW   = 14;
    localparam int MW   = 8;
    localparam int HALF = 1 << (DW - 1);
    localparam int FULL = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    am_mod_pipe_if #(.DW(DW), .MW(MW)) bus ();

    am_mod_pipe #(.DW(DW), .MW(MW)) dut (
        .clk_100M (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // model state
    int m_m, tgt_m, last_am;
    bit qv[$];
    int qd[$];

    function automatic longint fdiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int am_ref(int car, int mod, int m);
        longint x, c, env, y;
        x   = longint'(mod) - HALF;
        c   = longint'(car) - HALF;
        env = (HALF - 1) + fdiv(x * m, 1 << MW);
        y   = fdiv(env * c, 1 << DW);
        return int'(y + HALF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive, advance model, check outputs 1 time unit after the edge
    task automatic cyc(input bit r, input bit iv, input int car, input int mod,
                       input int dep, input bit ld);
        bit exp_v;
        rst            = r;
        bus.in_valid   = iv;
        bus.carrier    = car[DW-1:0];
        bus.modulating = mod[DW-1:0];
        bus.depth      = dep[MW-1:0];
        bus.depth_load = ld;
        @(posedge clk);
        exp_v = 1'b0;
        if (r) begin
            qv.delete();
            qd.delete();
            m_m = 0; tgt_m = 0; last_am = HALF;
        end else begin
            qv.push_back(iv);
            qd.push_back(iv ? am_ref(car, mod, m_m) : 0);
`ifdef AM_DEPTH_RAMP_EN
            if (ld) tgt_m = dep;
            if (iv && m_m != tgt_m) m_m = m_m + ((tgt_m > m_m) ? 1 : -1);
`else
            if (ld) m_m = dep;
`endif
            if (qv.size() > 3) begin
                exp_v = qv.pop_front();
                if (exp_v) last_am = qd.pop_front();
                else void'(qd.pop_front());
            end
        end
        #1;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
        chk("am_sig", {18'b0, bus.am_sig}, last_am);
`ifdef AM_DEPTH_RAMP_EN
        chk("depth_busy", {31'b0, bus.depth_busy}, {31'b0, tgt_m != m_m});
`else
        chk("depth_busy", {31'b0, bus.depth_busy}, 32'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int mod, car, n;
        m_m = 0; tgt_m = 0; last_am = HALF;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, FULL, FULL, 200, 1);

        // zero modulation: every sample gives 12287
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            mod = (i == 0) ? 0 : (i == 23) ? FULL : int'($urandom_range(FULL));
            cyc(0, 1, FULL, mod, 0, 0);
        end
        idle(4);

        // midscale modulating, arbitrary depth (ramp may still be running)
        cyc(0, 0, 0, 0, int'($urandom_range(255)), 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, (i % 2 == 1) ? HALF : 0, HALF, 0, 0);
        idle(4);

        // half depth, wait for ramp to finish, then full-scale samples
        cyc(0, 0, 0, 0, 128, 1);
        n = 0;
        while (m_m != 128 && n < 300) begin
            cyc(0, 1, int'($urandom_range(FULL)), int'($urandom_range(FULL)), 0, 0);
            n++;
        end
        chk("ramp_done", m_m, 128);
        for (int i = 0; i < 4; i++) cyc(0, 1, FULL, FULL, 0, 0);
        idle(4);

        // ramp 0 -> 4 with continuous samples, then gapped 4 -> 8
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 4, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, FULL, FULL, 0, 0);
        cyc(0, 0, 0, 0, 8, 1);
        for (int i = 0; i < 12; i++) cyc(0, i % 2 == 0, FULL, FULL, 0, 0);
        idle(4);

        // retarget down mid-ramp: 0 -> 6, stop at 3, retarget to 1
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 6, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, FULL, FULL, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, FULL, FULL, 0, 0);
        // load together with a sample, then retarget to current depth
        cyc(0, 1, FULL, FULL, 5, 1);
        cyc(0, 1, FULL, FULL, 3, 1);
        cyc(0, 1, FULL, FULL, 3, 1);
        idle(4);

        // load of 200 with a sample on the same edge, then a second sample
        cyc(0, 1, FULL, FULL, 200, 1);
        cyc(0, 1, FULL, FULL, 0, 0);
        cyc(0, 1, 1234, 15000, 0, 0);
        idle(4);

        // alternating bubbles, then reset mid-stream
        for (int i = 0; i < 10; i++)
            cyc(0, i % 2 == 0, int'($urandom_range(FULL)), int'($urandom_range(FULL)), 0, 0);
        cyc(0, 1, FULL, 0, 0, 0);
        cyc(0, 1, 0, FULL, 90, 1);
        cyc(1, 1, FULL, FULL, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, i > 2, FULL, FULL, 0, 0);

        // random traffic with occasional depth loads and resets
        for (int i = 0; i < 600; i++) begin
            car = int'($urandom_range(FULL));
            mod = ($urandom_range(7) == 0) ? FULL : int'($urandom_range(FULL));
            cyc($urandom_range(199) == 0, $urandom_range(3) != 0, car, mod,
                int'($urandom_range(255)), $urandom_range(15) == 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/am_mod_pipe.md
# am_mod_pipe

Parametrised, pipelined AM modulator for the DDS datapath. Takes an offset-binary carrier and modulating sample from the DDS cores and a fine-grained modulation depth. Produces an offset-binary AM sample for the DAC path. Supersedes the fixed 14-bit, 4-bit-index modulator with:
- configurable widths
- a valid-qualified 3-stage pipeline
- a glitch-free depth ramp on depth changes

## Interface
Parameters:
- DW, 14, sample width (carrier, modulating, output), offset binary
- MW, 8, depth width; m = depth/2^MW, range 0 .. (2^MW−1)/2^MW

Ports:
- clk_100M  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  carrier/modulating valid this cycle
- carrier  in  DW  carrier sample, offset binary
- modulating  in  DW  modulating sample, offset binary
- depth  in  MW  requested modulation depth
- depth_load  in  1  one-cycle strobe; capture depth as new target
- out_valid  out  1  am_sig valid
- am_sig  out  DW  AM sample, offset binary
- depth_busy  out  1  depth ramp in progress

## Operation
- Convert to signed: x = {~modulating[DW−1], modulating[DW−2:0]}; c likewise from carrier.
- Stage 1 register: x, c, m_cur.
- Stage 2:
  - p = x·m_cur, signed, DW+MW bits
  - s = p >>> MW, arithmetic shift (floor)
  - env = (2^(DW−1)−1) + s, unsigned DW bits
  - env never leaves [0, 2^DW−1] for any input; no clipping logic.
- Stage 3:
  - y = (env·c) >>> DW, signed DW bits; always in range.
  - am_sig = {~y[DW−1], y[DW−2:0]}.
- Pipeline advances every cycle. There is no backpressure. Bubbles (in_valid=0) propagate as out_valid=0, and am_sig holds its last value.
- Depth FSM states:
  - IDLE: on depth_load, target ← depth. Go to UP if target > m_cur, DOWN if target < m_cur, otherwise stay.
  - UP / DOWN: each cycle with in_valid=1, m_cur steps ±1. When m_cur equals target after the step, go to IDLE.
  - depth_load during UP/DOWN retargets. Direction is recomputed in the same cycle, and going to IDLE is immediate if the new target equals m_cur.
  - depth_busy = 1 in UP/DOWN.
- Simultaneous in_valid and depth_load: that sample uses the pre-update m_cur. Target updates, and one step toward the new target is taken on that same edge.
- Sample uses m_cur as registered in stage 1. A depth step never affects an in-flight sample.

## Timing
- Latency: 3 cycles. Sample presented with in_valid at edge n appears with out_valid at edge n+3.
- Throughput: one sample per cycle.
- Ramp: |target − m_cur| accepted samples to complete. Cycles without in_valid do not step.
- Reset (rst=1 at an edge), values after that edge:
  - out_valid=0, am_sig=2^(DW−1) (midscale)
  - m_cur=0, target=0, FSM=IDLE, depth_busy=0
  - all pipeline valid bits cleared
- Reset mid-ramp or mid-pipeline discards all state; no output is produced for samples in flight.

## Configuration
- AM_DEPTH_RAMP_EN defined: depth FSM and ramp as above.
- AM_DEPTH_RAMP_EN undefined:
  - m_cur ← depth on the edge where depth_load=1, regardless of in_valid.
  - The sample accepted on that edge uses the old m_cur.
  - depth_busy tied 0; no FSM.

## Test plan
All scenarios use DW=14, MW=8.
- Zero modulation: reset, depth=0 loaded, carrier=16383, modulating=0..16383 sweep -> am_sig=12287 for every sample, 3 cycles after each in_valid.
- Midscale modulating: modulating=8192, carrier=0, any depth -> am_sig=4096; carrier=8192 -> am_sig=8192.
- Half depth, ramp fully complete at depth=128: modulating=16383, carrier=16383 -> env=12286, am_sig=14334.
- Ramp (macro on): depth_load with depth=4 from m_cur=0, continuous in_valid -> depth_busy high for exactly 4 cycles; samples 1–4 use m=0,1,2,3; sample 5 uses 4.
  - Repeat with in_valid gapped -> step only on valid cycles.
  - Retarget to 1 while m_cur=3 -> DOWN, 2 steps.
- Bubbles/reset: alternating in_valid -> out_valid pattern delayed 3 cycles.
  - Assert rst mid-stream -> next cycle out_valid=0, am_sig=8192, depth_busy=0; no stale outputs afterward.
- Macro off: depth_load=1, depth=200 with in_valid=1 -> that sample uses old depth; next sample uses 200; depth_busy always 0.
